vga_timing_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 30 +++
 rtl/sync_delay_line.sv | 27 ++
 rtl/vga_timing_gen.sv | 106 ++++++++++
 tb/tb_vga_timing_gen.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: default 640x480@60 mode, total helper,
// and the per-pixel sync bundle carried through the delay line.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Fields are active-high "asserted" flags; pin polarity is applied at the output.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } sync_bundle_t;

  localparam sync_bundle_t SYNC_IDLE = '0;

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register for the sync bundle; every stage resets to idle.
module sync_delay_line
  import video_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  input  sync_bundle_t din,
  output sync_bundle_t dout
);

  sync_bundle_t stage_q [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= SYNC_IDLE;
    end else if (en) begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable raster timing generator: stage-0 counters for the pixel
// generator, sync/de/start signals delayed to match its latency.
module vga_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 2,
  parameter int CW       = 10
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_SS    = H_ACTIVE + H_FP;
  localparam int H_SE    = H_SS + H_SYNC;
  localparam int V_SS    = V_ACTIVE + V_FP;
  localparam int V_SE    = V_SS + V_SYNC;

  generate
    if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
      $error("vga_timing_gen: sync widths must be at least 1");
    end
    if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_bad_dly
      $error("vga_timing_gen: PIPE_DLY must be in 1..8");
    end
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
      $error("vga_timing_gen: CW too narrow for the frame totals");
    end
  endgenerate

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  logic [CW-1:0] hcount_q;
  logic [CW-1:0] vcount_q;
  logic          en_q;
  sync_bundle_t  stage0;
  sync_bundle_t  dly_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
      en_q     <= 1'b0;
    end else begin
      en_q <= pix_en;
      if (pix_en) begin
        if (hcount_q == H_LAST) begin
          hcount_q <= '0;
          vcount_q <= (vcount_q == V_LAST) ? '0 : vcount_q + CW'(1);
        end else begin
          hcount_q <= hcount_q + CW'(1);
        end
      end
    end
  end

  // Vsync decodes vcount only, so it flips exactly when hcount wraps to 0.
  always_comb begin
    stage0    = SYNC_IDLE;
    stage0.de = (hcount_q < CW'(H_ACTIVE)) && (vcount_q < CW'(V_ACTIVE));
    stage0.hs = (hcount_q >= CW'(H_SS)) && (hcount_q < CW'(H_SE));
    stage0.vs = (vcount_q >= CW'(V_SS)) && (vcount_q < CW'(V_SE));
    stage0.ls = (hcount_q == '0);
    stage0.fs = (hcount_q == '0) && (vcount_q == '0);
  end

  sync_delay_line #(
    .DEPTH (PIPE_DLY)
  ) u_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (pix_en),
    .din     (stage0),
    .dout    (dly_out)
  );

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = dly_out.hs ^ ~HS_POL;
  assign vsync       = dly_out.vs ^ ~VS_POL;
  assign de          = dly_out.de;
  // Gating with en_q keeps each pulse to one clock when pix_en is sparse.
  assign line_start  = dly_out.ls & en_q;
  assign frame_start = dly_out.fs & en_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small modes, enable gating, delay,
// polarity, default-mode line timing and asynchronous mid-frame reset.
module tb_vga_timing_gen;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic pix_en  = 1'b0;

  always #5 clock = ~clock;

  // Instance map: 0 small/D1, 1 default, 2 small/D3, 3 small/D1 active-high syncs
  logic [9:0] hc [4];
  logic [9:0] vc [4];
  logic       hs [4];
  logic       vs [4];
  logic       de [4];
  logic       ls [4];
  logic       fs [4];

  int compared   = 0;
  int mismatched = 0;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(1), .CW(10)
  ) u_small (
    .clock(clock), .reset_n(reset_n), .pix_en(pix_en),
    .hcount(hc[0]), .vcount(vc[0]), .hsync(hs[0]), .vsync(vs[0]),
    .de(de[0]), .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_timing_gen u_def (
    .clock(clock), .reset_n(reset_n), .pix_en(pix_en),
    .hcount(hc[1]), .vcount(vc[1]), .hsync(hs[1]), .vsync(vs[1]),
    .de(de[1]), .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3), .CW(10)
  ) u_p3 (
    .clock(clock), .reset_n(reset_n), .pix_en(pix_en),
    .hcount(hc[2]), .vcount(vc[2]), .hsync(hs[2]), .vsync(vs[2]),
    .de(de[2]), .line_start(ls[2]), .frame_start(fs[2])
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(1), .CW(10)
  ) u_pol (
    .clock(clock), .reset_n(reset_n), .pix_en(pix_en),
    .hcount(hc[3]), .vcount(vc[3]), .hsync(hs[3]), .vsync(vs[3]),
    .de(de[3]), .line_start(ls[3]), .frame_start(fs[3])
  );

  function automatic logic [24:0] obs(input int s);
    return {hc[s], vc[s], hs[s], vs[s], de[s], ls[s], fs[s]};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    pix_en  = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [24:0] e;
    @(negedge clock);
    reset_n = 1'b0;
    pix_en  = 1'b1;
    @(negedge clock);
    @(negedge clock);
    e = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    compared++;
    if (obs(0) !== e) begin
      mismatched++;
      $display("FAIL reset_small: got %h want %h", obs(0), e);
    end
    e = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    compared++;
    if (obs(3) !== e) begin
      mismatched++;
      $display("FAIL reset_pol: got %h want %h", obs(3), e);
    end
    $display("test_reset done: compared=%0d mismatched=%0d", compared, mismatched);
  endtask

  // PIPE_DLY=1, pix_en=1: outputs show the position one clock earlier.
  task automatic test_small_mode();
    logic [24:0] e;
    logic hs_e, vs_e, de_e, ls_e, fs_e;
    int p, ph, pv, fs_cnt, fs_first, fs_second;
    do_reset();
    pix_en = 1'b1;
    fs_cnt = 0; fs_first = -1; fs_second = -1;
    for (int k = 1; k <= 96; k++) begin
      @(negedge clock);
      if (k >= 1) begin
        p = k - 1; ph = p % 8; pv = (p / 8) % 6;
        de_e = (ph < 4) && (pv < 3);
        hs_e = !(ph == 5 || ph == 6);
        vs_e = !(pv == 4);
        ls_e = (ph == 0);
        fs_e = (ph == 0) && (pv == 0);
      end
      e = {10'(k % 8), 10'((k / 8) % 6), hs_e, vs_e, de_e, ls_e, fs_e};
      compared++;
      if (obs(0) !== e) begin
        mismatched++;
        $display("FAIL small_k%0d: got %h want %h", k, obs(0), e);
      end
      if (fs[0] === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k; else if (fs_second < 0) fs_second = k;
      end
    end
    compared++;
    if (fs_cnt !== 2 || fs_second - fs_first !== 48) begin
      mismatched++;
      $display("FAIL small_frame_period: got count %0d period %0d want count 2 period 48",
               fs_cnt, fs_second - fs_first);
    end
    $display("test_small_mode done: compared=%0d mismatched=%0d", compared, mismatched);
  endtask

  // pix_en alternates 1,0: state moves every second clock, pulses last one clock.
  task automatic test_pix_en_toggle();
    logic [24:0] e;
    logic hs_e, vs_e, de_e, ls_e, fs_e, en;
    int edges, p, ph, pv, fs_cnt, fs_first, fs_second;
    do_reset();
    edges = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
    for (int c = 0; c < 192; c++) begin
      en = (c % 2 == 0);
      pix_en = en;
      @(negedge clock);
      if (en) edges++;
      if (edges >= 1) begin
        p = edges - 1; ph = p % 8; pv = (p / 8) % 6;
        de_e = (ph < 4) && (pv < 3);
        hs_e = !(ph == 5 || ph == 6);
        vs_e = !(pv == 4);
        ls_e = en && (ph == 0);
        fs_e = en && (ph == 0) && (pv == 0);
      end else begin
        de_e = 1'b0; hs_e = 1'b1; vs_e = 1'b1; ls_e = 1'b0; fs_e = 1'b0;
      end
      e = {10'(edges % 8), 10'((edges / 8) % 6), hs_e, vs_e, de_e, ls_e, fs_e};
      compared++;
      if (obs(0) !== e) begin
        mismatched++;
        $display("FAIL toggle_c%0d: got %h want %h", c, obs(0), e);
      end
      if (fs[0] === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = c; else if (fs_second < 0) fs_second = c;
      end
    end
    compared++;
    if (fs_cnt !== 2 || fs_second - fs_first !== 96) begin
      mismatched++;
      $display("FAIL toggle_frame_period: got count %0d period %0d want count 2 period 96",
               fs_cnt, fs_second - fs_first);
    end
    pix_en = 1'b1;
    $display("test_pix_en_toggle done: compared=%0d mismatched=%0d", compared, mismatched);
  endtask

  task automatic test_pipe_delay();
    logic [24:0] e;
    logic hs_e, vs_e, de_e, ls_e, fs_e;
    int p, ph, pv, fs_first;
    do_reset();
    pix_en = 1'b1;
    fs_first = -1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clock);
      if (k >= 3) begin
        p = k - 3; ph = p % 8; pv = (p / 8) % 6;
        de_e = (ph < 4) && (pv < 3);
        hs_e = !(ph == 5 || ph == 6);
        vs_e = !(pv == 4);
        ls_e = (ph == 0);
        fs_e = (ph == 0) && (pv == 0);
      end else begin
        de_e = 1'b0; hs_e = 1'b1; vs_e = 1'b1; ls_e = 1'b0; fs_e = 1'b0;
      end
      e = {10'(k % 8), 10'((k / 8) % 6), hs_e, vs_e, de_e, ls_e, fs_e};
      compared++;
      if (obs(2) !== e) begin
        mismatched++;
        $display("FAIL dly3_k%0d: got %h want %h", k, obs(2), e);
      end
      if (fs[2] === 1'b1 && fs_first < 0) fs_first = k;
    end
    compared++;
    if (fs_first !== 3) begin
      mismatched++;
      $display("FAIL dly3_first_fs: got %0d want 3", fs_first);
    end
    $display("test_pipe_delay done: compared=%0d mismatched=%0d", compared, mismatched);
  endtask

  task automatic test_polarity();
    logic [1:0] got, want;
    int p, ph, pv;
    do_reset();
    pix_en = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clock);
      p = k - 1; ph = p % 8; pv = (p / 8) % 6;
      got  = {hs[3], vs[3]};
      want = {1'(ph == 5 || ph == 6), 1'(pv == 4)};
      compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL pol_k%0d: got hs/vs %b want %b", k, got, want);
      end
    end
    $display("test_polarity done: compared=%0d mismatched=%0d", compared, mismatched);
  endtask

  // Default 800x525 mode, PIPE_DLY=2: two full lines of horizontal timing.
  task automatic test_default_lines();
    int hs_cnt, hs_first, hs_last, de_cnt, de_first, de_last, vs_cnt;
    int ls_cnt, ls_first, ls_second;
    logic [19:0] pos800, pos1600;
    hs_cnt = 0; hs_first = -1; hs_last = -1; de_cnt = 0; de_first = -1; de_last = -1;
    vs_cnt = 0; ls_cnt = 0; ls_first = -1; ls_second = -1;
    pos800 = '0; pos1600 = '0;
    do_reset();
    pix_en = 1'b1;
    for (int k = 1; k <= 1602; k++) begin
      @(negedge clock);
      if (k <= 801) begin
        if (hs[1] === 1'b0) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = k;
          hs_last = k;
        end
        if (de[1] === 1'b1) begin
          de_cnt++;
          if (de_first < 0) de_first = k;
          de_last = k;
        end
      end
      if (vs[1] !== 1'b1) vs_cnt++;
      if (ls[1] === 1'b1) begin
        ls_cnt++;
        if (ls_first < 0) ls_first = k; else if (ls_second < 0) ls_second = k;
      end
      if (k == 800)  pos800  = {hc[1], vc[1]};
      if (k == 1600) pos1600 = {hc[1], vc[1]};
    end
    compared++;
    if (hs_cnt !== 96 || hs_first !== 658 || hs_last !== 753) begin
      mismatched++;
      $display("FAIL def_hsync: got cnt %0d at %0d..%0d want 96 at 658..753",
               hs_cnt, hs_first, hs_last);
    end
    compared++;
    if (de_cnt !== 640 || de_first !== 2 || de_last !== 641) begin
      mismatched++;
      $display("FAIL def_de: got cnt %0d at %0d..%0d want 640 at 2..641",
               de_cnt, de_first, de_last);
    end
    compared++;
    if (ls_cnt !== 3 || ls_first !== 2 || ls_second !== 802) begin
      mismatched++;
      $display("FAIL def_line_start: got cnt %0d first %0d second %0d want 3, 2, 802",
               ls_cnt, ls_first, ls_second);
    end
    compared++;
    if (pos800 !== {10'd0, 10'd1} || pos1600 !== {10'd0, 10'd2}) begin
      mismatched++;
      $display("FAIL def_line_wrap: got %h/%h want %h/%h",
               pos800, pos1600, {10'd0, 10'd1}, {10'd0, 10'd2});
    end
    compared++;
    if (vs_cnt !== 0) begin
      mismatched++;
      $display("FAIL def_vsync_idle: got %0d asserted clocks want 0", vs_cnt);
    end
    $display("test_default_lines done: compared=%0d mismatched=%0d", compared, mismatched);
  endtask

  task automatic test_reset_mid_frame();
    logic [24:0] e;
    do_reset();
    pix_en = 1'b1;
    repeat (38) @(negedge clock);
    e = {10'd6, 10'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    compared++;
    if (obs(0) !== e) begin
      mismatched++;
      $display("FAIL midframe_pre: got %h want %h", obs(0), e);
    end
    #2;
    reset_n = 1'b0;
    #1;
    e = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    compared++;
    if (obs(0) !== e) begin
      mismatched++;
      $display("FAIL midframe_async: got %h want %h", obs(0), e);
    end
    @(negedge clock);
    @(negedge clock);
    compared++;
    if (obs(0) !== e) begin
      mismatched++;
      $display("FAIL midframe_hold: got %h want %h", obs(0), e);
    end
    reset_n = 1'b1;
    @(negedge clock);
    e = {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    compared++;
    if (obs(0) !== e) begin
      mismatched++;
      $display("FAIL midframe_restart: got %h want %h", obs(0), e);
    end
    $display("test_reset_mid_frame done: compared=%0d mismatched=%0d", compared, mismatched);
  endtask

  initial begin
    test_reset();
    test_small_mode();
    test_pix_en_toggle();
    test_pipe_delay();
    test_polarity();
    test_default_lines();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
